// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the raw button and the divided sample
// strobe, then runs a four-state stability FSM on each strobe rising edge.
// Produces a debounced level, one-clk press/release pulses and a press count.
module button_debouncer #(
    parameter int unsigned STABLE_SAMPLES = 3,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slow_CLK,
    input  logic       btn_in,
    output logic       btn_state,
    output logic       btn_pressed,
    output logic       btn_released,
    output logic [7:0] press_count
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_SAMPLES);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHECK,
        PRESSED,
        RELEASE_CHECK
    } state_t;

    logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
    logic [SYNC_STAGES-1:0] slow_sync_q, slow_sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   slow_prev_q, slow_prev_d;
    logic                   armed_q, armed_d;
    state_t                 state_q, state_d;
    logic [3:0]             stable_cnt_q, stable_cnt_d;
    logic                   btn_state_q, btn_state_d;
    logic                   btn_pressed_q, btn_pressed_d;
    logic                   btn_released_q, btn_released_d;
    logic [7:0]             press_count_q, press_count_d;

    logic       btn_s;
    logic       slow_s;
    logic       sample_tick;
    logic [3:0] cnt_inc;

    // Synchronizer shift, previous-strobe register and tick arming.
    // vld tracks when the synchronizer holds real samples rather than reset
    // zeros; ticks are armed only once a genuine low strobe has been seen, so
    // a strobe already high at reset release cannot fake a rising edge.
    always_comb begin
        btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], btn_in};
        slow_sync_d = {slow_sync_q[SYNC_STAGES-2:0], slow_CLK};
        vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
        btn_s       = btn_sync_q[SYNC_STAGES-1];
        slow_s      = slow_sync_q[SYNC_STAGES-1];
        slow_prev_d = slow_s;
        armed_d     = armed_q | (vld_q[SYNC_STAGES-1] & ~slow_s);
        sample_tick = slow_s & ~slow_prev_q & armed_q;
    end

    // Next-state and stability counter, advanced only on sample ticks.
    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        cnt_inc      = stable_cnt_q + 4'd1;
        if (sample_tick) begin
            case (state_q)
                RELEASED: begin
                    if (btn_s) begin
                        if (STABLE_N == 4'd1) begin
                            state_d      = PRESSED;
                            stable_cnt_d = '0;
                        end else begin
                            state_d      = PRESS_CHECK;
                            stable_cnt_d = 4'd1;
                        end
                    end
                end
                PRESS_CHECK: begin
                    if (!btn_s) begin
                        state_d      = RELEASED;
                        stable_cnt_d = '0;
                    end else if (cnt_inc == STABLE_N) begin
                        state_d      = PRESSED;
                        stable_cnt_d = '0;
                    end else begin
                        stable_cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        if (STABLE_N == 4'd1) begin
                            state_d      = RELEASED;
                            stable_cnt_d = '0;
                        end else begin
                            state_d      = RELEASE_CHECK;
                            stable_cnt_d = 4'd1;
                        end
                    end
                end
                RELEASE_CHECK: begin
                    if (btn_s) begin
                        state_d      = PRESSED;
                        stable_cnt_d = '0;
                    end else if (cnt_inc == STABLE_N) begin
                        state_d      = RELEASED;
                        stable_cnt_d = '0;
                    end else begin
                        stable_cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d      = RELEASED;
                    stable_cnt_d = '0;
                end
            endcase
        end
    end

    // Registered outputs derived from the next state so they align with it.
    always_comb begin
        btn_state_d    = (state_d == PRESSED) || (state_d == RELEASE_CHECK);
        btn_pressed_d  = (state_d == PRESSED) && (state_q != PRESSED)
                         && (state_q != RELEASE_CHECK);
        btn_released_d = (state_d == RELEASED) && (state_q != RELEASED)
                         && (state_q != PRESS_CHECK);
        press_count_d  = press_count_q + 8'(btn_pressed_d);
    end

    // All state, synchronizer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_sync_q     <= '0;
            slow_sync_q    <= '0;
            vld_q          <= '0;
            slow_prev_q    <= 1'b0;
            armed_q        <= 1'b0;
            state_q        <= RELEASED;
            stable_cnt_q   <= '0;
            btn_state_q    <= 1'b0;
            btn_pressed_q  <= 1'b0;
            btn_released_q <= 1'b0;
            press_count_q  <= '0;
        end else begin
            btn_sync_q     <= btn_sync_d;
            slow_sync_q    <= slow_sync_d;
            vld_q          <= vld_d;
            slow_prev_q    <= slow_prev_d;
            armed_q        <= armed_d;
            state_q        <= state_d;
            stable_cnt_q   <= stable_cnt_d;
            btn_state_q    <= btn_state_d;
            btn_pressed_q  <= btn_pressed_d;
            btn_released_q <= btn_released_d;
            press_count_q  <= press_count_d;
        end
    end

    assign btn_state    = btn_state_q;
    assign btn_pressed  = btn_pressed_q;
    assign btn_released = btn_released_q;
    assign press_count  = press_count_q;

endmodule
